res_seq_ctrl: RTL

- Sequencer for the reservoir datapath.
- Time-multiplexes N_PE multiply-accumulate PEs over all N_NODES reservoir nodes to compute one state update x(t+1) from x(t).
- Per update: issues weight addresses, state-column indices, accumulator clear/MAC strobes, write-back strobes and a final commit that swaps the state buffers.
- Sits between the top-level run control and the PE array / xstate buffers inside the reservoir top.

---
 rtl/res_seq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/res_seq_ctrl.sv
// Reservoir update sequencer: time-multiplexes N_PE MAC PEs over N_NODES nodes per state update.
// Optional macro RES_FREE_RUN_EN: with start held, COMMIT chains straight into the next update.
module res_seq_ctrl #(
    parameter int N_NODES = 16,
    parameter int N_PE    = 2,
    parameter int PE_LAT  = 2,
    parameter int IDX_W   = 4,
    parameter int PASS_W  = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    hold,
    output logic                    busy,
    output logic                    done,
    output logic [PASS_W-1:0]       pass_idx,
    output logic [IDX_W-1:0]        col_idx,
    output logic [PASS_W+IDX_W-1:0] w_addr,
    output logic                    pe_clr,
    output logic                    pe_mac,
    output logic                    wb_en,
    output logic [IDX_W-1:0]        wb_base,
    output logic                    x_commit,
    output logic [CNT_W-1:0]        step_cnt
);

    localparam int N_PASS = N_NODES / N_PE;
    localparam int DRN_W  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(N_NODES - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_PASS - 1);
    localparam logic [DRN_W-1:0]  LAST_DRN  = DRN_W'(PE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_MAC, S_DRAIN, S_WB, S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0]  col_q, col_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  wb_base_q, wb_base_d;
    logic              clr_q, clr_d, mac_q, mac_d, wb_q, wb_d, commit_q, commit_d;

    // The registered state is the step currently presented on the outputs; a held
    // edge keeps that step but drops its strobe, so the next released edge moves on.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        col_d     = col_q;
        drn_d     = drn_q;
        cnt_d     = cnt_q;
        clr_d     = 1'b0;
        mac_d     = 1'b0;
        wb_d      = 1'b0;
        commit_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && !hold) begin
                state_d = S_CLR;
                pass_d  = '0;
                col_d   = '0;
                clr_d   = 1'b1;
            end
        end else if (!hold) begin
            case (state_q)
                S_CLR: begin
                    state_d = S_MAC;
                    col_d   = '0;
                    mac_d   = 1'b1;
                end
                S_MAC: begin
                    if (col_q == LAST_COL) begin
                        state_d = S_DRAIN;
                        drn_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                        mac_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drn_q == LAST_DRN) begin
                        state_d = S_WB;
                        wb_d    = 1'b1;
                    end else begin
                        drn_d = drn_q + 1'b1;
                    end
                end
                S_WB: begin
                    col_d = '0;
                    if (pass_q != LAST_PASS) begin
                        state_d = S_CLR;
                        pass_d  = pass_q + 1'b1;
                        clr_d   = 1'b1;
                    end else begin
                        state_d  = S_COMMIT;
                        pass_d   = '0;
                        commit_d = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_COMMIT: begin
`ifdef RES_FREE_RUN_EN
                    if (start) begin
                        state_d = S_CLR;
                        pass_d  = '0;
                        col_d   = '0;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
        wb_base_d = wb_d ? IDX_W'(int'(pass_d) * N_PE) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pass_q    <= '0;
            col_q     <= '0;
            drn_q     <= '0;
            cnt_q     <= '0;
            wb_base_q <= '0;
            clr_q     <= 1'b0;
            mac_q     <= 1'b0;
            wb_q      <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            col_q     <= col_d;
            drn_q     <= drn_d;
            cnt_q     <= cnt_d;
            wb_base_q <= wb_base_d;
            clr_q     <= clr_d;
            mac_q     <= mac_d;
            wb_q      <= wb_d;
            commit_q  <= commit_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = commit_q;
    assign x_commit = commit_q;
    assign pass_idx = pass_q;
    assign col_idx  = col_q;
    assign w_addr   = {pass_q, col_q};
    assign pe_clr   = clr_q;
    assign pe_mac   = mac_q;
    assign wb_en    = wb_q;
    assign wb_base  = wb_base_q;
    assign step_cnt = cnt_q;

endmodule
